// File: rtl/crc_pkg.sv
// Shared CRC encoder definitions: FSM state encoding, standard generator
// polynomials and a small sizing helper.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    APPEND = 2'd2
  } state_e;

  // Normal-form polynomials with the implicit x^16 term dropped.
  localparam logic [15:0] CRC16_8005 = 16'h8005;
  localparam logic [15:0] CRC16_1021 = 16'h1021;

  // Number of DW-bit beats needed to ship a CRC_W-bit checksum.
  function automatic int crc_beats(input int crc_w, input int dw);
    return crc_w / dw;
  endfunction

endpackage

// File: rtl/crc_param_encoder_if.sv
// Streaming bus between a message source, the CRC encoder and a codeword sink.
// master = the environment (drives input beats, accepts output beats),
// slave  = the encoder.
interface crc_param_encoder_if #(
  parameter int DW = 1
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/crc_step.sv
// Combinational CRC update: folds one DW-bit beat into the running CRC,
// MSB first, non-reflected.
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_8005),
  parameter int               DW    = 1
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [DW-1:0]    data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] acc;

  // Bit-serial division unrolled across the beat so it settles in one cycle.
  always_comb begin
    acc = crc_i;
    for (int i = DW - 1; i >= 0; i--) begin
      if (acc[CRC_W-1] ^ data_i[i]) begin
        acc = (acc << 1) ^ POLY;
      end else begin
        acc = acc << 1;
      end
    end
    crc_o = acc;
  end

endmodule

// File: rtl/crc_param_encoder.sv
// Parameterised CRC encoder: passes message beats through with one cycle of
// latency, then appends (crc ^ XOROUT) as CRC_W/DW beats, MSB first.
module crc_param_encoder
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_8005),
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic [CRC_W-1:0] XOROUT = '0,
  parameter int               DW     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_param_encoder_if.slave   bus,
  output logic                 busy
);

  localparam int NBEATS = crc_beats(CRC_W, DW);
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(NBEATS);

  if ((CRC_W < 8) || (CRC_W > 32)) begin : g_bad_crc_w
    $error("crc_param_encoder: CRC_W must lie within 8..32");
  end
  if ((CRC_W % DW) != 0) begin : g_bad_dw
    $error("crc_param_encoder: CRC_W must be a multiple of DW");
  end

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic [CRC_W-1:0] crc_nxt;
  logic             in_ready;
  logic             in_hs;
  logic             out_hs;
  logic             out_free;

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .DW    (DW)
  ) u_step (
    .crc_i  (crc_q),
    .data_i (bus.in_data),
    .crc_o  (crc_nxt)
  );

  // Handshake qualifiers; the output register is the only buffer, so a new
  // input beat is taken only when that register is empty or draining.
  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    in_ready = rst && (state_q != APPEND) && out_free;
    in_hs    = bus.in_valid && in_ready;
    out_hs   = out_valid_q && bus.out_ready;
  end

  // Next-state, CRC, beat counter and output register loading.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_hs) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE, DATA: begin
        if (in_hs) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.in_data;
          out_last_d  = 1'b0;
          if (bus.in_last) begin
            // Fold XOROUT in now so APPEND only has to shift beats out.
            state_d = APPEND;
            crc_d   = crc_nxt ^ XOROUT;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            crc_d   = crc_nxt;
          end
        end
      end

      APPEND: begin
        if (out_hs && out_last_q) begin
          state_d    = IDLE;
          crc_d      = INIT;
          cnt_d      = '0;
          out_last_d = 1'b0;
        end else if (out_free && (cnt_q != CNT_DONE)) begin
          out_valid_d = 1'b1;
          out_data_d  = crc_q[CRC_W-1 -: DW];
          out_last_d  = (cnt_q == CNT_LAST);
          crc_d       = crc_q << DW;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        crc_d   = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_crc_param_encoder.sv
// Self-checking bench for crc_param_encoder: three configurations
// (CRC-16/8005 DW=8, CRC-16/8005 DW=1, CRC-16/1021 init FFFF DW=8)
// compared against a polynomial long-division reference model.
module tb_crc_param_encoder;
  import crc_pkg::*;

  typedef logic [8:0] beat_t;
  typedef beat_t      beatq_t[$];
  typedef logic [7:0] byteq_t[$];
  typedef bit         bitq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ordy = 1'b1;
  bit   stall_en = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic busy_a, busy_b, busy_c;

  crc_param_encoder_if #(.DW(8)) ifa ();
  crc_param_encoder_if #(.DW(1)) ifb ();
  crc_param_encoder_if #(.DW(8)) ifc ();

  assign ifc.in_valid  = ifa.in_valid;
  assign ifc.in_data   = ifa.in_data;
  assign ifc.in_last   = ifa.in_last;
  assign ifa.out_ready = ordy;
  assign ifb.out_ready = ordy;
  assign ifc.out_ready = ordy;

  crc_param_encoder #(.CRC_W(16), .POLY(CRC16_8005), .INIT(16'h0000),
                      .XOROUT(16'h0000), .DW(8))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave), .busy(busy_a));

  crc_param_encoder #(.CRC_W(16), .POLY(CRC16_8005), .INIT(16'h0000),
                      .XOROUT(16'h0000), .DW(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave), .busy(busy_b));

  crc_param_encoder #(.CRC_W(16), .POLY(CRC16_1021), .INIT(16'hFFFF),
                      .XOROUT(16'h0000), .DW(8))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave), .busy(busy_c));

  always #5 clk = ~clk;

  // Sink backpressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ordy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collection and hold-while-stalled observation.
  beatq_t qa, qb, qc;
  logic       sa, sb, sc;
  logic [9:0] pa, pb, pc;
  logic [9:0] ca, cb, cc;
  assign ca = {ifa.out_valid, ifa.out_last, ifa.out_data};
  assign cb = {ifb.out_valid, ifb.out_last, 7'd0, ifb.out_data};
  assign cc = {ifc.out_valid, ifc.out_last, ifc.out_data};

  always @(negedge clk) begin
    if (!rst) begin
      sa <= 1'b0;
      sb <= 1'b0;
      sc <= 1'b0;
    end else begin
      viol <= viol + int'(sa && (ca !== pa)) + int'(sb && (cb !== pb))
                   + int'(sc && (cc !== pc));
      if (ifa.out_valid && ifa.out_ready) qa.push_back(ca[8:0]);
      if (ifb.out_valid && ifb.out_ready) qb.push_back(cb[8:0]);
      if (ifc.out_valid && ifc.out_ready) qc.push_back(cc[8:0]);
      sa <= ifa.out_valid && !ifa.out_ready;
      sb <= ifb.out_valid && !ifb.out_ready;
      sc <= ifc.out_valid && !ifc.out_ready;
      pa <= ca;
      pb <= cb;
      pc <= cc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: CRC as the remainder of the augmented message divided by the
  // full generator, with the initial register value folded into the first
  // CRC_W augmented bits.
  function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input bitq_t msg);
    bitq_t aug;
    longint unsigned rem, gen;
    aug = msg;
    repeat (w) aug.push_back(1'b0);
    for (int i = 0; i < w; i++) aug[i] = aug[i] ^ init[w-1-i];
    gen = (64'd1 << w) | 64'(poly);
    rem = 0;
    foreach (aug[i]) begin
      rem = (rem << 1) | 64'(aug[i]);
      if (rem[w]) rem = rem ^ gen;
    end
    return 32'(rem);
  endfunction

  function automatic bitq_t to_bits(input byteq_t d);
    bitq_t b;
    foreach (d[i]) for (int k = 7; k >= 0; k--) b.push_back(d[i][k]);
    return b;
  endfunction

  task automatic drive_a(input byteq_t d, input bit with_last);
    foreach (d[i]) begin
      int n;
      bit acc;
      ifa.in_valid = 1'b1;
      ifa.in_data  = d[i];
      ifa.in_last  = with_last && (i == d.size() - 1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = ifa.in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) chk("in_accept_timeout_a", 32'(acc), 32'd1);
    end
    ifa.in_valid = 1'b0;
    ifa.in_last  = 1'b0;
  endtask

  task automatic drive_b(input bitq_t d);
    foreach (d[i]) begin
      int n;
      bit acc;
      ifb.in_valid = 1'b1;
      ifb.in_data  = d[i];
      ifb.in_last  = (i == d.size() - 1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = ifb.in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) chk("in_accept_timeout_b", 32'(acc), 32'd1);
    end
    ifb.in_valid = 1'b0;
    ifb.in_last  = 1'b0;
  endtask

  task automatic wait_out(input int na, input int nb, input int nc);
    int n;
    n = 0;
    while ((qa.size() < na || qb.size() < nb || qc.size() < nc) && n < 2000) begin
      cycles(1);
      n++;
    end
    if (n >= 2000) chk("output_timeout", 32'(n), 32'd0);
    cycles(4);
  endtask

  // Byte-wide frame: pass-through bytes then CRC high, CRC low (last).
  task automatic check8(input string tag, input beatq_t got, input byteq_t d,
                        input logic [15:0] crc);
    int n;
    n = d.size();
    chk({tag, "_count"}, 32'(got.size()), 32'(n + 2));
    if (got.size() == n + 2) begin
      foreach (d[i]) chk({tag, "_data"}, 32'(got[i]), 32'({1'b0, d[i]}));
      chk({tag, "_crc_hi"}, 32'(got[n]),     32'({1'b0, crc[15:8]}));
      chk({tag, "_crc_lo"}, 32'(got[n + 1]), 32'({1'b1, crc[7:0]}));
    end
  endtask

  // Bit-wide frame: pass-through bits then 16 CRC bits, last on the final one.
  task automatic check1(input string tag, input beatq_t got, input bitq_t d,
                        input logic [15:0] crc);
    int n;
    n = d.size();
    chk({tag, "_count"}, 32'(got.size()), 32'(n + 16));
    if (got.size() == n + 16) begin
      foreach (d[i]) chk({tag, "_data"}, 32'(got[i]), 32'({1'b0, 7'd0, d[i]}));
      for (int k = 0; k < 16; k++)
        chk({tag, "_crc_bit"}, 32'(got[n + k]), 32'({(k == 15), 7'd0, crc[15-k]}));
    end
  endtask

  initial begin
    byteq_t msg, one, d, part;
    beatq_t g1, g2;
    bitq_t  bits;

    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0;

    // Reset state
    cycles(3);
    @(negedge clk);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_last",  32'(ifa.out_last),  32'd0);
    chk("rst_out_data",  32'(ifa.out_data),  32'd0);
    chk("rst_busy",      32'(busy_a),        32'd0);
    chk("rst_in_ready",  32'(ifa.in_ready),  32'd0);
    chk("rst_in_ready_b", 32'(ifb.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready",   32'(ifa.in_ready), 32'd1);
    chk("post_rst_in_ready_b", 32'(ifb.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // "123456789" without stalls
    stall_en = 1'b0;
    drive_a(msg, 1'b1);
    wait_out(11, 0, 11);
    check8("check_8005", qa, msg, 16'hFEE8);
    check8("check_1021", qc, msg, 16'h29B1);
    qa.delete(); qc.delete();

    // Same frame under random backpressure
    stall_en = 1'b1;
    drive_a(msg, 1'b1);
    wait_out(11, 0, 11);
    check8("stall_8005", qa, msg, 16'hFEE8);
    check8("stall_1021", qc, msg, 16'h29B1);
    chk("stable_while_stalled", 32'(viol), 32'd0);
    qa.delete(); qc.delete();

    // Single-beat frame immediately followed by a full frame
    stall_en = 1'b0;
    one = '{8'h00};
    drive_a(one, 1'b1);
    drive_a(msg, 1'b1);
    wait_out(14, 0, 14);
    g1 = {}; g2 = {};
    foreach (qa[i]) if (i < 3) g1.push_back(qa[i]); else g2.push_back(qa[i]);
    check8("b2b_first_8005",  g1, one, 16'h0000);
    check8("b2b_second_8005", g2, msg, 16'hFEE8);
    g1 = {}; g2 = {};
    foreach (qc[i]) if (i < 3) g1.push_back(qc[i]); else g2.push_back(qc[i]);
    check8("b2b_first_1021",  g1, one, 16'(model_crc(16, 32'h1021, 32'hFFFF, to_bits(one))));
    check8("b2b_second_1021", g2, msg, 16'h29B1);
    qa.delete(); qc.delete();

    // Random frames under random backpressure
    stall_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      d = {};
      repeat ($urandom_range(1, 12)) d.push_back(8'($urandom_range(0, 255)));
      drive_a(d, 1'b1);
      wait_out(d.size() + 2, 0, d.size() + 2);
      check8("rand_8005", qa, d, 16'(model_crc(16, 32'h8005, 32'h0000, to_bits(d))));
      check8("rand_1021", qc, d, 16'(model_crc(16, 32'h1021, 32'hFFFF, to_bits(d))));
      qa.delete(); qc.delete();
    end
    chk("stable_while_stalled_rand", 32'(viol), 32'd0);

    // Reset in the middle of a frame, then restart it
    stall_en = 1'b0;
    part = '{8'h31, 8'h32, 8'h33, 8'h34};
    drive_a(part, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("midrst_busy",      32'(busy_a),        32'd0);
    chk("midrst_in_ready",  32'(ifa.in_ready),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    cycles(5);
    chk("midrst_no_stale_a", 32'(qa.size()), 32'd0);
    chk("midrst_no_stale_c", 32'(qc.size()), 32'd0);
    chk("midrst_idle",       32'(busy_a),    32'd0);
    drive_a(msg, 1'b1);
    wait_out(11, 0, 11);
    check8("restart_8005", qa, msg, 16'hFEE8);
    check8("restart_1021", qc, msg, 16'h29B1);
    qa.delete(); qc.delete();

    // One bit per beat
    bits = to_bits(msg);
    drive_b(bits);
    wait_out(0, 88, 0);
    check1("dw1_8005", qb, bits, 16'hFEE8);
    qb.delete();

    stall_en = 1'b1;
    bits = {};
    repeat (20) bits.push_back(1'($urandom_range(0, 1)));
    drive_b(bits);
    wait_out(0, 36, 0);
    check1("dw1_rand", qb, bits, 16'(model_crc(16, 32'h8005, 32'h0000, bits)));
    qb.delete();
    chk("stable_while_stalled_dw1", 32'(viol), 32'd0);
    stall_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
